// File: rtl/mix_sequencer.sv
// Six-channel time-multiplexed mixer: one shared 8x8 multiplier/accumulator,
// optional per-channel gain slew limiting, fixed 7-cycle frame latency.
module mix_sequencer #(
  parameter int RAMP_STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic [47:0] wave_in,
  input  logic [47:0] gain_in,
  output logic [7:0]  mixed_out,
  output logic        mix_valid,
  output logic        busy,
  output logic        overrun
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      ch_q, ch_d;
  logic [18:0]     acc_q, acc_d;
  logic [5:0][7:0] wave_cap_q, wave_cap_d;
  logic [7:0]      mixed_out_q, mixed_out_d;
  logic            mix_valid_q, mix_valid_d;
  logic            overrun_q, overrun_d;

  logic [5:0][7:0] gain_tgt;
  logic [7:0]      w_sel, g_sel;
  logic [15:0]     prod;
  logic [18:0]     acc_sum;
  logic [10:0]     acc_shr;
  logic            accum_en;

  assign gain_tgt = gain_in;
  assign w_sel    = wave_cap_q[ch_q];
  assign prod     = w_sel * g_sel;
  assign acc_sum  = acc_q + 19'(prod);
  assign acc_shr  = acc_sum[18:8];
  assign accum_en = (state_q == ACCUM);

  generate
    if (RAMP_STEP == 0) begin : g_live
      assign g_sel = gain_tgt[ch_q];
    end else begin : g_ramp
      localparam logic [8:0] STEP = 9'(RAMP_STEP);
      logic [5:0][7:0] gain_cur_q, gain_cur_d;
      logic [7:0]      tgt;
      logic [8:0]      up_gap, dn_gap;

      assign tgt    = gain_tgt[ch_q];
      // The frame uses the pre-update gain; the step lands for the next frame.
      assign g_sel  = gain_cur_q[ch_q];
      assign up_gap = {1'b0, tgt} - {1'b0, g_sel};
      assign dn_gap = {1'b0, g_sel} - {1'b0, tgt};

      always_comb begin
        gain_cur_d = gain_cur_q;
        if (accum_en) begin
          if (tgt >= g_sel)
            gain_cur_d[ch_q] = (up_gap <= STEP) ? tgt : g_sel + 8'(RAMP_STEP);
          else
            gain_cur_d[ch_q] = (dn_gap <= STEP) ? tgt : g_sel - 8'(RAMP_STEP);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gain_cur_q <= '0;
        else        gain_cur_q <= gain_cur_d;
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    wave_cap_d  = wave_cap_q;
    mixed_out_d = mixed_out_q;
    mix_valid_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          wave_cap_d = wave_in;
          acc_d      = '0;
          ch_d       = '0;
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        overrun_d = sample_tick;
        acc_d     = acc_sum;
        ch_d      = ch_q + 3'd1;
        // Result is registered as the last product lands, so mix_valid is
        // high during OUTPUT, the 7th busy cycle.
        if (ch_q == 3'd5) begin
          state_d     = OUTPUT;
          mixed_out_d = (|acc_shr[10:8]) ? 8'hFF : acc_shr[7:0];
          mix_valid_d = 1'b1;
        end
      end
      OUTPUT: begin
        overrun_d = sample_tick;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      acc_q       <= '0;
      wave_cap_q  <= '0;
      mixed_out_q <= '0;
      mix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      wave_cap_q  <= wave_cap_d;
      mixed_out_q <= mixed_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mixed_out = mixed_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_mix_sequencer.sv
// Drives two mixers (no ramp / ramp of 4) with shared stimulus and checks
// them against a frame-level arithmetic model.
module tb_mix_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic [47:0] wave_in = '0;
  logic [47:0] gain_in = '0;
  logic [7:0]  out0, out4;
  logic        mv0, mv4, busy0, busy4, ov0, ov4;

  always #5 clk = ~clk;

  mix_sequencer #(.RAMP_STEP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .wave_in(wave_in),
    .gain_in(gain_in), .mixed_out(out0), .mix_valid(mv0), .busy(busy0), .overrun(ov0));
  mix_sequencer #(.RAMP_STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .wave_in(wave_in),
    .gain_in(gain_in), .mixed_out(out4), .mix_valid(mv4), .busy(busy4), .overrun(ov4));

  int total = 0;
  int bad   = 0;
  int cur4[6];
  int hold0 = 0;
  int hold4 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mix(input logic [47:0] w, input int g[6]);
    int s = 0;
    for (int k = 0; k < 6; k++) s += int'(w[8*k +: 8]) * g[k];
    s = s / 256;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic int slew(input int c, input int t);
    int d = t - c;
    if (d <= 4 && d >= -4) return t;
    return (d > 0) ? c + 4 : c - 4;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out0"}, out0, 0);  chk({tag, "_out4"}, out4, 0);
    chk({tag, "_mv0"}, mv0, 0);    chk({tag, "_mv4"}, mv4, 0);
    chk({tag, "_busy0"}, busy0, 0); chk({tag, "_busy4"}, busy4, 0);
    chk({tag, "_ov0"}, ov0, 0);    chk({tag, "_ov4"}, ov4, 0);
  endtask

  // Called at a negedge with the DUTs idle; returns at the negedge of the
  // first idle cycle so the next frame is ticked right after mix_valid.
  task automatic run_frame(input logic [47:0] w, input logic [47:0] g,
                           input int ovr_at, input bit glitch);
    int g0[6];
    int g4[6];
    int exp0, exp4;
    for (int k = 0; k < 6; k++) begin
      g0[k] = int'(g[8*k +: 8]);
      g4[k] = cur4[k];
      cur4[k] = slew(cur4[k], g0[k]);
    end
    exp0 = mix(w, g0);
    exp4 = mix(w, g4);
    wave_in = w;
    gain_in = g;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    if (glitch) wave_in = {$urandom, $urandom};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk("busy0", busy0, (c <= 7));
      chk("busy4", busy4, (c <= 7));
      chk("mv0", mv0, (c == 7));
      chk("mv4", mv4, (c == 7));
      chk("ov0", ov0, (ovr_at != 0 && c == ovr_at + 1));
      chk("ov4", ov4, (ovr_at != 0 && c == ovr_at + 1));
      chk("out0", out0, (c >= 7) ? exp0 : hold0);
      chk("out4", out4, (c >= 7) ? exp4 : hold4);
      sample_tick = (c == ovr_at);
    end
    sample_tick = 1'b0;
    hold0 = exp0;
    hold4 = exp4;
  endtask

  initial begin
    logic [47:0] w, g;
    int ramp_tbl[6];
    ramp_tbl = '{0, 3, 7, 11, 15, 15};
    for (int k = 0; k < 6; k++) cur4[k] = 0;

    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single channel full scale, first tick straight after reset.
    run_frame(48'h0000_0000_00FF, 48'h0000_0000_00FF, 0, 1'b0);
    chk("single_fe", out0, 8'hFE);
    // Saturation.
    run_frame({6{8'hFF}}, {6{8'hFF}}, 0, 1'b1);
    chk("saturate", out0, 8'hFF);
    // Mid-range mix.
    run_frame({6{8'hC0}}, {6{8'h2A}}, 0, 1'b0);
    chk("mid_bd", out0, 8'hBD);
    // Overrun tick 3 cycles after acceptance, and one in OUTPUT.
    run_frame({6{8'hC0}}, {6{8'h2A}}, 3, 1'b1);
    chk("ovr_same", out0, 8'hBD);
    run_frame({6{8'h40}}, {6{8'h80}}, 7, 1'b0);

    // Reset mid-frame aborts with no mix_valid.
    wave_in = 48'h0000_FF00_0000;
    gain_in = 48'h0000_1000_0000;
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(posedge clk);
    #1 chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cur4[k] = 0;
    hold0 = 0;
    hold4 = 0;

    // Ramp from zero on channel 3.
    for (int f = 0; f < 6; f++) begin
      run_frame(48'h0000_FF00_0000, 48'h0000_1000_0000, 0, 1'b0);
      chk($sformatf("ramp%0d", f), out4, ramp_tbl[f]);
    end

    // Random frames; gains held per frame, waves may glitch after capture.
    for (int n = 0; n < 25; n++) begin
      w = {$urandom, $urandom};
      g = ($urandom_range(0, 4) == 0) ? {6{8'hFF}} : {$urandom, $urandom};
      run_frame(w, g, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0,
                1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
